// File: rtl/fir_tdm_sequencer_if.sv
// Stream and coefficient-port bundle for the time-multiplexed FIR sequencer.
// master = sample source / consumer side, slave = the sequencer itself.
interface fir_tdm_sequencer_if #(
    parameter int N_TAPS = 21,
    parameter int DW     = 16,
    parameter int CW     = 8
);
    localparam int AW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/fir_tdm_sequencer.sv
// FIR filter sharing one multiply-accumulate across N_TAPS taps (IDLE -> MAC -> OUT).
// Define FIR_SAT_EN to clamp the output to DW bits and raise a sticky overflow flag.
module fir_tdm_sequencer #(
    parameter int N_TAPS    = 21,
    parameter int DW        = 16,
    parameter int CW        = 8,
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 7
) (
    input  logic                      clk,
    input  logic                      rst_p,
    fir_tdm_sequencer_if.slave        bus,
    output logic                      busy,
    output logic                      overflow
);
    localparam int AW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int KW = $clog2(N_TAPS + 1);
    localparam logic [AW-1:0] TAP_LAST = AW'(N_TAPS - 1);
    localparam logic [KW-1:0] CNT_LAST = KW'(N_TAPS);
    localparam int RSH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_W-1:0] RND = (OUT_SHIFT > 0) ? (ACC_W'(1) << RSH) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    state_t state_reg, state_next;

    logic signed [DW-1:0]    hist_reg [N_TAPS];
    logic signed [CW-1:0]    coef_reg [N_TAPS];
    logic signed [DW-1:0]    hist_q;
    logic signed [CW-1:0]    coef_q;
    logic [AW-1:0]           wp_reg;
    logic [AW-1:0]           rd_h_reg;
    logic [AW-1:0]           rd_k_reg;
    logic [KW-1:0]           cnt_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [DW-1:0]           m_data_reg;

    logic                    accept;
    logic                    coef_wr;
    logic signed [DW+CW-1:0] prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] rnd_sum;
    logic [DW-1:0]           out_val;

    assign accept  = (state_reg == ST_IDLE) && bus.s_valid;
    assign coef_wr = (state_reg == ST_IDLE) && bus.coef_we && (bus.coef_addr <= TAP_LAST);

    assign bus.s_ready = (state_reg == ST_IDLE);
    assign bus.m_valid = (state_reg == ST_OUT);
    assign bus.m_data  = m_data_reg;
    assign busy        = (state_reg == ST_MAC) || (state_reg == ST_OUT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.s_valid) state_next = ST_MAC;
            ST_MAC:  if (cnt_reg == CNT_LAST) state_next = ST_OUT;
            ST_OUT:  if (bus.m_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: the product of the previous cycle's registered reads is added now.
    assign prod    = hist_q * coef_q;
    assign acc_sum = acc_reg + {{(ACC_W-DW-CW){prod[DW+CW-1]}}, prod};
    assign rnd_sum = acc_sum + RND;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] OMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] OMIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [ACC_W-1:0] r_full;
    logic                    sat_hi;
    logic                    sat_lo;
    logic                    overflow_reg;

    assign r_full  = rnd_sum >>> OUT_SHIFT;
    assign sat_hi  = r_full > MAXV;
    assign sat_lo  = r_full < MINV;
    assign out_val = sat_hi ? OMAX : (sat_lo ? OMIN : r_full[DW-1:0]);
    assign overflow = overflow_reg;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            overflow_reg <= 1'b0;
        end else if ((state_reg == ST_MAC) && (cnt_reg == CNT_LAST) && (sat_hi || sat_lo)) begin
            overflow_reg <= 1'b1;
        end
    end
`else
    assign out_val  = DW'(rnd_sum >>> OUT_SHIFT);
    assign overflow = 1'b0;
`endif

    // Sample history and coefficient bank, each with one write and one registered read.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            for (int i = 0; i < N_TAPS; i++) begin
                hist_reg[i] <= '0;
                coef_reg[i] <= '0;
            end
            hist_q <= '0;
            coef_q <= '0;
        end else begin
            if (accept) begin
                hist_reg[wp_reg] <= bus.s_data;
            end
            if (coef_wr) begin
                coef_reg[bus.coef_addr] <= bus.coef_data;
            end
            hist_q <= hist_reg[rd_h_reg];
            coef_q <= coef_reg[rd_k_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_reg  <= ST_IDLE;
            wp_reg     <= '0;
            rd_h_reg   <= '0;
            rd_k_reg   <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            m_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                wp_reg   <= (wp_reg == TAP_LAST) ? '0 : wp_reg + 1'b1;
                rd_h_reg <= wp_reg;
                rd_k_reg <= '0;
                cnt_reg  <= '0;
                acc_reg  <= '0;
            end else if (state_reg == ST_MAC) begin
                cnt_reg  <= cnt_reg + 1'b1;
                rd_k_reg <= (rd_k_reg == TAP_LAST) ? '0 : rd_k_reg + 1'b1;
                rd_h_reg <= (rd_h_reg == '0) ? TAP_LAST : rd_h_reg - 1'b1;
                // Cycle 0 only issues the first read; products arrive one cycle later.
                if (cnt_reg != '0) begin
                    acc_reg <= acc_sum;
                end
                if (cnt_reg == CNT_LAST) begin
                    m_data_reg <= out_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Scoreboard bench for fir_tdm_sequencer: a reference model pushes expected outputs on
// every accepted sample; a monitor pops and compares them on each output handshake.
module tb_fir_tdm_sequencer;
    localparam int N     = 21;
    localparam int DW    = 16;
    localparam int CW    = 8;
    localparam int ACC_W = 32;
    localparam int SH    = 0;
    localparam int AW    = $clog2(N);

    typedef struct {
        longint data;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_p = 1'b1;
    logic busy;
    logic overflow;

    always #5 clk = ~clk;

    fir_tdm_sequencer_if #(.N_TAPS(N), .DW(DW), .CW(CW)) intf ();

    fir_tdm_sequencer #(
        .N_TAPS(N), .DW(DW), .CW(CW), .ACC_W(ACC_W), .OUT_SHIFT(SH)
    ) u_dut (
        .clk(clk),
        .rst_p(rst_p),
        .bus(intf.slave),
        .busy(busy),
        .overflow(overflow)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    int     ready_mode = 1;
    exp_t   eq[$];
    longint tq[$];
    longint hist_m[N];
    longint coef_m[N];
    int     wp_m = 0;
    bit     ovf_m = 1'b0;
    bit     mv_prev = 1'b0;
    longint last_data = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) intf.m_ready = 1'($urandom_range(0, 1));
        else                 intf.m_ready = (ready_mode == 1);
    end

    // Monitor: output latency on each rising m_valid, data/flag on each handshake.
    always @(negedge clk) begin
        if (!rst_p) begin
            if (intf.m_valid && !mv_prev) begin
                if (tq.size() != 0) begin
                    longint t;
                    t = tq.pop_front();
                    check_val("latency", cyc - t, N + 1);
                end else begin
                    check_val("spurious_valid", 1, 0);
                end
            end
            if (intf.m_valid && intf.m_ready) begin
                if (eq.size() != 0) begin
                    exp_t e;
                    e = eq.pop_front();
                    check_val("m_data", longint'($signed(intf.m_data)), e.data);
                    check_val("overflow", longint'(overflow), longint'(e.ovf));
                    $display("out %0d: m_data=%0d expected=%0d", cyc, $signed(intf.m_data), e.data);
                    last_data = longint'($signed(intf.m_data));
                end else begin
                    check_val("unexpected_output", 1, 0);
                end
            end
        end
        mv_prev = intf.m_valid;
    end

    function automatic exp_t model_out(input int base);
        exp_t   e;
        longint acc;
        longint r;
        logic [15:0] r16;
        acc = 0;
        for (int k = 0; k < N; k++) acc += hist_m[(base - k + N) % N] * coef_m[k];
        r = acc;
        if (SH > 0) r = r + (longint'(1) <<< (SH - 1));
        r = r >>> SH;
`ifdef FIR_SAT_EN
        if (r > 32767) begin
            r = 32767;
            ovf_m = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            ovf_m = 1'b1;
        end
        e.data = r;
`else
        r16 = r[15:0];
        e.data = longint'($signed(r16));
`endif
        e.ovf = ovf_m;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            hist_m[i] = 0;
            coef_m[i] = 0;
        end
        wp_m = 0;
        ovf_m = 1'b0;
        eq.delete();
        tq.delete();
    endtask

    // Present one sample (optionally with a coefficient write) until accepted.
    task automatic send(input logic signed [15:0] d, input bit we, input int addr, input logic signed [7:0] cv);
        int  waitc;
        bit  sr;
        int  base;
        waitc = 0;
        intf.s_valid   = 1'b1;
        intf.s_data    = d;
        intf.coef_we   = we;
        intf.coef_addr = AW'(addr);
        intf.coef_data = cv;
        forever begin
            @(negedge clk);
            sr = intf.s_ready;
            @(posedge clk);
            #1;
            if (sr) break;
            waitc++;
            if (waitc > 200) begin
                check_val("accept_timeout", 0, 1);
                break;
            end
        end
        intf.s_valid = 1'b0;
        intf.coef_we = 1'b0;
        if (sr) begin
            if (we && addr < N) coef_m[addr] = longint'(cv);
            hist_m[wp_m] = longint'(d);
            base = wp_m;
            wp_m = (wp_m == N - 1) ? 0 : wp_m + 1;
            eq.push_back(model_out(base));
            tq.push_back(cyc);
            $display("in  %0d: s_data=%0d", cyc, d);
        end
    endtask

    task automatic wcoef(input int addr, input logic signed [7:0] cv, input bit take);
        intf.coef_we   = 1'b1;
        intf.coef_addr = AW'(addr);
        intf.coef_data = cv;
        @(posedge clk);
        #1;
        intf.coef_we = 1'b0;
        if (take && addr < N) coef_m[addr] = longint'(cv);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((eq.size() != 0 || intf.m_valid) && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_val("drain_pending", longint'(eq.size()), 0);
    endtask

    task automatic run_impulse();
        ready_mode = 1;
        for (int k = 0; k < N; k++) wcoef(k, 8'(k + 1), 1'b1);
        send(16'sd1, 1'b0, 0, 8'sd0);
        for (int i = 0; i < N; i++) send(16'sd0, 1'b0, 0, 8'sd0);
        wait_drain();
        check_val("impulse_tail", last_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        longint exp_bp;
        logic signed [15:0] d;
        intf.s_valid = 1'b0;
        intf.s_data = '0;
        intf.coef_we = 1'b0;
        intf.coef_addr = '0;
        intf.coef_data = '0;
        intf.m_ready = 1'b1;
        model_clear();

        // Reset state
        rst_p = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_s_ready", longint'(intf.s_ready), 1);
        check_val("rst_m_valid", longint'(intf.m_valid), 0);
        check_val("rst_m_data", longint'(intf.m_data), 0);
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_overflow", longint'(overflow), 0);
        rst_p = 1'b0;
        @(posedge clk);
        #1;

        // Impulse response equals the coefficient ramp
        run_impulse();

        // Backpressure: output held while m_ready is low
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send(16'sd1234, 1'b0, 0, 8'sd0);
        exp_bp = eq[0].data;
        c = 0;
        while (!intf.m_valid && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_val("bp_valid", longint'(intf.m_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_hold", longint'($signed(intf.m_data)), exp_bp);
            check_val("bp_s_ready", longint'(intf.s_ready), 0);
            check_val("bp_busy", longint'(busy), 1);
            @(posedge clk);
            #1;
        end
        ready_mode = 1;
        c = 0;
        while (c < 10) begin
            @(negedge clk);
            if (intf.m_valid && intf.m_ready) break;
            c++;
        end
        @(posedge clk);
        #1;
        check_val("bp_release_valid", longint'(intf.m_valid), 0);
        check_val("bp_release_ready", longint'(intf.s_ready), 1);
        wait_drain();

        // Overflow: full-scale input with full-scale coefficients
        for (int k = 0; k < N; k++) wcoef(k, 8'sd127, 1'b1);
        for (int i = 0; i < N; i++) send(16'sd32767, 1'b0, 0, 8'sd0);
        wait_drain();
`ifdef FIR_SAT_EN
        check_val("ovf_last_out", last_data, 32767);
        check_val("ovf_flag", longint'(overflow), 1);
`else
        check_val("ovf_last_out", last_data, 30101);
        check_val("ovf_flag", longint'(overflow), 0);
`endif

        // Coefficient write during MAC is ignored; a write in IDLE takes effect
        for (int k = 0; k < N; k++) wcoef(k, 8'(10 - k), 1'b1);
        send(16'sd100, 1'b0, 0, 8'sd0);
        repeat (3) @(posedge clk);
        #1;
        wcoef(8, -8'sd50, 1'b0);
        wait_drain();
        wcoef(8, -8'sd50, 1'b1);
        send(-16'sd200, 1'b0, 0, 8'sd0);
        wait_drain();

        // Reset in the middle of MAC aborts the operation
        send(16'sd500, 1'b0, 0, 8'sd0);
        repeat (10) @(posedge clk);
        #1;
        rst_p = 1'b1;
        @(posedge clk);
        #1;
        rst_p = 1'b0;
        model_clear();
        check_val("midrst_m_valid", longint'(intf.m_valid), 0);
        check_val("midrst_s_ready", longint'(intf.s_ready), 1);
        check_val("midrst_busy", longint'(busy), 0);
        check_val("midrst_overflow", longint'(overflow), 0);
        run_impulse();

        // Random samples, random coefficient writes (some out of range), random m_ready
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            send(d, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 31)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        ready_mode = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
